// File: rtl/rgb565_gray_packer_if.sv
`default_nettype none
// ============================================================================
// Module   : rgb565_gray_packer_if
// Function : Pixel-in / packed-grayscale-out stream bundle for the packer.
// Revision : 1.0
// ============================================================================
interface rgb565_gray_packer_if #(
    parameter int PIXELS_PER_IN = 2
);
    logic [16*PIXELS_PER_IN-1:0] in_data;
    logic                        in_valid;
    logic                        in_last;
    logic                        in_ready;
    logic [31:0]                 out_data;
    logic                        out_valid;
    logic                        out_last;
    logic                        out_ready;

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_valid, out_last
    );

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_valid, out_last
    );
endinterface
`default_nettype wire

// File: rtl/rgb565_gray_packer.sv
`default_nettype none
// ============================================================================
// Module   : rgb565_gray_packer
// Function : Pipelined RGB565 -> 8-bit gray, packed four bytes per 32-bit word.
//            Define GRAYSCALE_ROUND_EN for round-half-up; default truncates.
// Revision : 1.0
// ============================================================================
module rgb565_gray_packer #(
    parameter int PIXELS_PER_IN = 2,
    parameter int R_COEF        = 54,
    parameter int G_COEF        = 183,
    parameter int B_COEF        = 19
) (
    input  wire                 clock,
    input  wire                 reset_n,
    rgb565_gray_packer_if.slave bus
);

    localparam int          LANES    = PIXELS_PER_IN;
    localparam logic [2:0]  c_lanes  = 3'(PIXELS_PER_IN);
    localparam logic [15:0] c_r_coef = 16'(R_COEF);
    localparam logic [15:0] c_g_coef = 16'(G_COEF);
    localparam logic [15:0] c_b_coef = 16'(B_COEF);
`ifdef GRAYSCALE_ROUND_EN
    localparam logic [15:0] c_rnd    = 16'd128;
`endif

    generate
        if (R_COEF + G_COEF + B_COEF != 256) begin : g_bad_coef
            $error("rgb565_gray_packer: R_COEF + G_COEF + B_COEF must equal 256");
        end
        if (PIXELS_PER_IN != 1 && PIXELS_PER_IN != 2) begin : g_bad_ppi
            $error("rgb565_gray_packer: PIXELS_PER_IN must be 1 or 2");
        end
    endgenerate

    logic        w_en;
    logic        r_s1_valid;
    logic        r_s1_last;
    logic        r_s2_valid;
    logic        r_s2_last;
    logic [7:0]  w_gray [LANES];

    logic [1:0]  r_fill;
    logic [31:0] r_asm;
    logic        r_done;
    logic        r_asm_last;
    logic [31:0] w_asm;
    logic [1:0]  w_slot;
    logic [2:0]  w_fill_sum;
    logic        w_word_done;

    logic [31:0] r_out_data;
    logic        r_out_valid;
    logic        r_out_last;

    assign w_en         = !r_out_valid || bus.out_ready;
    assign bus.in_ready = w_en;

    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            logic [15:0] w_pix;
            logic [7:0]  w_r8;
            logic [7:0]  w_g8;
            logic [7:0]  w_b8;
            logic [15:0] w_sum;
            logic [15:0] r_prod_r;
            logic [15:0] r_prod_g;
            logic [15:0] r_prod_b;
            logic [7:0]  r_gray;

            // Pixel 0 sits in the most significant half of the input word
            assign w_pix = bus.in_data[16*(LANES-1-i) +: 16];
            assign w_r8  = {w_pix[15:11], w_pix[15:13]};
            assign w_g8  = {w_pix[10:5],  w_pix[10:9]};
            assign w_b8  = {w_pix[4:0],   w_pix[4:2]};

`ifdef GRAYSCALE_ROUND_EN
            assign w_sum = r_prod_r + r_prod_g + r_prod_b + c_rnd;
`else
            assign w_sum = r_prod_r + r_prod_g + r_prod_b;
`endif

            always_ff @(posedge clock) begin
                if (w_en) begin
                    r_prod_r <= 16'(w_r8) * c_r_coef;
                    r_prod_g <= 16'(w_g8) * c_g_coef;
                    r_prod_b <= 16'(w_b8) * c_b_coef;
                    r_gray   <= 8'(w_sum >> 8);
                end
            end

            assign w_gray[i] = r_gray;
        end
    endgenerate

    // A finished word waits in r_asm for one cycle, so new bytes start from zero
    always_comb begin
        w_asm  = r_done ? 32'h0 : r_asm;
        w_slot = r_fill;
        for (int i = 0; i < LANES; i++) begin
            w_slot = r_fill + 2'(i);
            w_asm[{~w_slot, 3'b000} +: 8] = w_gray[i];
        end
    end

    assign w_fill_sum  = {1'b0, r_fill} + c_lanes;
    assign w_word_done = w_fill_sum[2];

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_last   <= 1'b0;
            r_s2_valid  <= 1'b0;
            r_s2_last   <= 1'b0;
            r_fill      <= 2'd0;
            r_asm       <= 32'h0;
            r_done      <= 1'b0;
            r_asm_last  <= 1'b0;
            r_out_data  <= 32'h0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else if (w_en) begin
            r_s1_valid  <= bus.in_valid;
            r_s1_last   <= bus.in_last;
            r_s2_valid  <= r_s1_valid;
            r_s2_last   <= r_s1_last;
            r_out_valid <= r_done;
            if (r_done) begin
                r_out_data <= r_asm;
                r_out_last <= r_asm_last;
            end
            if (r_s2_valid) begin
                r_asm <= w_asm;
                if (w_word_done || r_s2_last) begin
                    r_done     <= 1'b1;
                    r_asm_last <= r_s2_last;
                    r_fill     <= 2'd0;
                end else begin
                    r_done     <= 1'b0;
                    r_fill     <= w_fill_sum[1:0];
                end
            end else begin
                r_done <= 1'b0;
                if (r_done) begin
                    r_asm <= 32'h0;
                end
            end
        end
    end

    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid;
    assign bus.out_last  = r_out_last;

endmodule
`default_nettype wire

// File: tb/tb_rgb565_gray_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rgb565_gray_packer
// Function : Self-checking bench for rgb565_gray_packer (2- and 1-pixel builds).
// Revision : 1.0
// ============================================================================
module tb_rgb565_gray_packer;

    localparam int R_W = 54;
    localparam int G_W = 183;
    localparam int B_W = 19;
`ifdef GRAYSCALE_ROUND_EN
    localparam int          RND     = 128;
    localparam logic [31:0] C_PRIM  = 32'hFF0036B6;
    localparam logic [31:0] C_FLUSH = 32'h13FF0000;
    localparam logic [31:0] C_P1    = 32'hFF00B613;
`else
    localparam int          RND     = 0;
    localparam logic [31:0] C_PRIM  = 32'hFF0035B6;
    localparam logic [31:0] C_FLUSH = 32'h12FF0000;
    localparam logic [31:0] C_P1    = 32'hFF00B612;
`endif

    logic clock;
    logic reset_n;
    int   n_tests;
    int   n_fail;

    rgb565_gray_packer_if #(.PIXELS_PER_IN(2)) bus2 ();
    rgb565_gray_packer_if #(.PIXELS_PER_IN(1)) bus1 ();

    rgb565_gray_packer #(.PIXELS_PER_IN(2), .R_COEF(R_W), .G_COEF(G_W), .B_COEF(B_W)) dut2 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus2)
    );

    rgb565_gray_packer #(.PIXELS_PER_IN(1), .R_COEF(R_W), .G_COEF(G_W), .B_COEF(B_W)) dut1 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model state: pending gray bytes per line, expected and observed words
    logic [7:0]  cur2 [$];
    logic [7:0]  cur1 [$];
    logic [32:0] exp2 [$];
    logic [32:0] got2 [$];
    logic [32:0] exp1 [$];
    logic [32:0] got1 [$];

    always begin
        @(negedge clock);
        #1;
        if (reset_n && bus2.out_valid && bus2.out_ready) got2.push_back({bus2.out_last, bus2.out_data});
        if (reset_n && bus1.out_valid && bus1.out_ready) got1.push_back({bus1.out_last, bus1.out_data});
    end

    function automatic logic [7:0] gray(input logic [15:0] p);
        int r5, g6, b5, r8, g8, b8, acc;
        r5  = int'(p[15:11]);
        g6  = int'(p[10:5]);
        b5  = int'(p[4:0]);
        r8  = r5 * 8 + r5 / 4;
        g8  = g6 * 4 + g6 / 16;
        b8  = b5 * 8 + b5 / 4;
        acc = R_W * r8 + G_W * g8 + B_W * b8 + RND;
        return 8'(acc / 256);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_accept(input int which, input logic [31:0] d, input logic l);
        logic [7:0]  bytes [$];
        logic [31:0] w;
        if (which == 2) begin
            bytes = cur2;
            bytes.push_back(gray(d[31:16]));
            bytes.push_back(gray(d[15:0]));
        end else begin
            bytes = cur1;
            bytes.push_back(gray(d[15:0]));
        end
        if (l || bytes.size() == 4) begin
            w = 32'h0;
            for (int i = 0; i < bytes.size(); i++) w[8*(3-i) +: 8] = bytes[i];
            if (which == 2) exp2.push_back({l, w});
            else            exp1.push_back({l, w});
            bytes.delete();
        end
        if (which == 2) cur2 = bytes;
        else            cur1 = bytes;
    endtask

    task automatic drive(input int which, input logic v, input logic [31:0] d, input logic l, input logic rdy);
        if (which == 2) begin
            bus2.in_valid = v; bus2.in_data = d; bus2.in_last = l; bus2.out_ready = rdy;
        end else begin
            bus1.in_valid = v; bus1.in_data = d[15:0]; bus1.in_last = l; bus1.out_ready = rdy;
        end
    endtask

    function automatic logic ready_of(input int which);
        return (which == 2) ? bus2.in_ready : bus1.in_ready;
    endfunction

    // Offers one word until accepted; returns at the negedge after the accepting edge
    task automatic send(input int which, input logic [31:0] d, input logic l);
        logic acc;
        int   t;
        acc = 1'b0;
        t   = 0;
        while (!acc && t < 100) begin
            @(negedge clock);
            drive(which, 1'b1, d, l, 1'b1);
            #1;
            acc = ready_of(which);
            @(posedge clock);
            t++;
        end
        chk("send_accepted", 64'(acc), 64'd1);
        if (acc) model_accept(which, d, l);
        @(negedge clock);
        drive(which, 1'b0, 32'h0, 1'b0, 1'b1);
    endtask

    task automatic stream(input int which, input int n, input int gap_pct, input int stall_pct,
                          input int last_pct, input bit toggle);
        int          sent, cyc;
        logic [31:0] d;
        logic        l, pend, rdy, acc, offer;
        sent = 0; cyc = 0; pend = 1'b0; d = 32'h0; l = 1'b0;
        while (sent < n && cyc < 5000) begin
            @(negedge clock);
            cyc++;
            rdy   = ($urandom_range(99) >= stall_pct);
            offer = toggle ? (cyc % 2 == 0) : ($urandom_range(99) >= gap_pct);
            if (!pend && offer) begin
                d    = $urandom;
                l    = ($urandom_range(99) < last_pct) || (sent == n - 1);
                pend = 1'b1;
            end
            drive(which, pend, d, l, rdy);
            #1;
            acc = pend && ready_of(which);
            @(posedge clock);
            if (acc) begin
                model_accept(which, d, l);
                pend = 1'b0;
                sent++;
            end
        end
        @(negedge clock);
        drive(which, 1'b0, 32'h0, 1'b0, 1'b1);
        chk($sformatf("stream%0d_sent", which), 64'(sent), 64'(n));
    endtask

    task automatic check_out(input int which, input string tag);
        logic [32:0] e [$];
        logic [32:0] g [$];
        int          t, m;
        t = 0;
        while (t < 500 && ((which == 2) ? (got2.size() < exp2.size()) : (got1.size() < exp1.size()))) begin
            @(negedge clock);
            t++;
        end
        repeat (10) @(negedge clock);
        if (which == 2) begin e = exp2; g = got2; exp2.delete(); got2.delete(); end
        else            begin e = exp1; g = got1; exp1.delete(); got1.delete(); end
        chk({tag, "_count"}, 64'(g.size()), 64'(e.size()));
        m = (g.size() < e.size()) ? g.size() : e.size();
        for (int i = 0; i < m; i++) chk($sformatf("%s_word%0d", tag, i), 64'(g[i]), 64'(e[i]));
    endtask

    logic [31:0] bw [8];
    int          idx, stall;
    bit          started;
    logic [31:0] held;
    logic        bacc;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset_n = 1'b0;
        drive(2, 1'b0, 32'h0, 1'b0, 1'b0);
        drive(1, 1'b0, 32'h0, 1'b0, 1'b0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        #1;
        chk("rst_out_valid", 64'(bus2.out_valid), 64'd0);
        chk("rst_out_last",  64'(bus2.out_last),  64'd0);
        chk("rst_out_data",  64'(bus2.out_data),  64'd0);
        chk("rst_in_ready",  64'(bus2.in_ready),  64'd1);
        chk("rst_in_ready1", 64'(bus1.in_ready),  64'd1);
        drive(2, 1'b0, 32'h0, 1'b0, 1'b1);
        drive(1, 1'b0, 32'h0, 1'b0, 1'b1);

        // Primaries with latency: visible only after the third edge past the accept
        send(2, 32'hFFFF0000, 1'b0);
        send(2, 32'hF80007E0, 1'b1);
        chk("lat_k0", 64'(bus2.out_valid), 64'd0);
        @(negedge clock);
        chk("lat_k1", 64'(bus2.out_valid), 64'd0);
        @(negedge clock);
        chk("lat_k2", 64'(bus2.out_valid), 64'd0);
        @(negedge clock);
        chk("lat_k3", 64'(bus2.out_valid), 64'd1);
        chk("prim_data", 64'(bus2.out_data), 64'(C_PRIM));
        chk("prim_last", 64'(bus2.out_last), 64'd1);
        check_out(2, "prim");

        // Partial flush
        send(2, 32'h001FFFFF, 1'b1);
        repeat (3) @(negedge clock);
        chk("flush_valid", 64'(bus2.out_valid), 64'd1);
        chk("flush_data",  64'(bus2.out_data),  64'(C_FLUSH));
        chk("flush_last",  64'(bus2.out_last),  64'd1);
        check_out(2, "flush");

        // Backpressure: stall the consumer for 5 cycles once output appears
        for (int i = 0; i < 8; i++) bw[i] = $urandom;
        idx = 0; stall = 0; started = 1'b0; held = 32'h0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clock);
            if (!started && bus2.out_valid) begin
                started = 1'b1;
                stall   = 5;
                held    = bus2.out_data;
            end
            if (idx < 8) drive(2, 1'b1, bw[idx], idx == 7, stall == 0);
            else         drive(2, 1'b0, 32'h0, 1'b0, stall == 0);
            #1;
            if (stall > 0) begin
                chk("bp_in_ready",  64'(bus2.in_ready),  64'd0);
                chk("bp_out_valid", 64'(bus2.out_valid), 64'd1);
                chk("bp_out_data",  64'(bus2.out_data),  64'(held));
                stall--;
            end
            bacc = bus2.in_valid && bus2.in_ready;
            @(posedge clock);
            if (bacc) begin
                model_accept(2, bw[idx], idx == 7);
                idx++;
            end
        end
        @(negedge clock);
        drive(2, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("bp_started", 64'(started), 64'd1);
        chk("bp_sent", 64'(idx), 64'd8);
        chk("bp_words", 64'(exp2.size()), 64'd4);
        check_out(2, "bp");

        // One pixel per input word
        send(1, 32'h0000FFFF, 1'b0);
        send(1, 32'h00000000, 1'b0);
        send(1, 32'h000007E0, 1'b0);
        send(1, 32'h0000001F, 1'b0);
        repeat (3) @(negedge clock);
        chk("p1_valid", 64'(bus1.out_valid), 64'd1);
        chk("p1_data",  64'(bus1.out_data),  64'(C_P1));
        chk("p1_last",  64'(bus1.out_last),  64'd0);
        check_out(1, "p1");

        // Reset mid-operation discards the partial word
        send(2, 32'h12345678, 1'b0);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        cur2.delete();
        exp2.delete();
        send(2, 32'h00000000, 1'b0);
        send(2, 32'hFFFFFFFF, 1'b1);
        repeat (3) @(negedge clock);
        chk("rstmid_data", 64'(bus2.out_data), 64'h0000FFFF);
        chk("rstmid_last", 64'(bus2.out_last), 64'd1);
        check_out(2, "rstmid");

        // Dense versus toggled in_valid
        stream(2, 16, 0, 0, 0, 1'b0);
        check_out(2, "dense");
        stream(2, 16, 0, 0, 0, 1'b1);
        check_out(2, "bubble");

        // Randomised traffic with gaps, stalls and random line ends
        stream(2, 300, 30, 30, 15, 1'b0);
        check_out(2, "rand2");
        stream(1, 200, 30, 30, 15, 1'b0);
        check_out(1, "rand1");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rgb565_gray_packer.md
# rgb565_gray_packer

Streaming, pipelined RGB565-to-8-bit-grayscale converter with parametrised pixel count per input word and channel weights. Each 8-bit grayscale result is packed into 32-bit output words. The block sits between the camera/DMA pixel stream and the grayscale frame-buffer writer. Grayscale bytes are packed four per output word so that the buffer memory is written at full width. Channels are expanded to 8 bits before weighting, so full white maps to 0xFF.

## Interface
- PIXELS_PER_IN, 2, RGB565 pixels per input word. Legal values are 1 and 2.
- R_COEF, 54, red weight.
- G_COEF, 183, green weight.
- B_COEF, 19, blue weight.
- R_COEF + G_COEF + B_COEF must equal 256; simulation `$error`s at elaboration otherwise.
- clock  input  1  single clock; all logic on the rising edge.
- reset_n  input  1  synchronous, active-low reset.
- in_data  input  16*PIXELS_PER_IN  pixels; pixel 0 in the most significant 16 bits.
- in_valid  input  1  in_data/in_last valid.
- in_last  input  1  final word of a line; flushes a partial output word.
- in_ready  output  1  block accepts the input word this cycle.
- out_data  output  32  grayscale bytes; first pixel in [31:24].
- out_valid  output  1  out_data/out_last valid.
- out_last  output  1  word contains the last pixel of the line.
- out_ready  input  1  consumer accepts the output word.

## Operation
- Channel expansion by bit replication:
  - R8 = {r5, r5[4:2]}
  - G8 = {g6, g6[5:4]}
  - B8 = {b5, b5[4:2]}
- Gray = (R_COEF*R8 + G_COEF*G8 + B_COEF*B8 + RND) >> 8.
  - Accumulator is 16 bits unsigned; the maximum is 65408, so it never overflows.
  - RND depends on the macro; see Configuration.
- Pipeline, each stage carrying a valid bit:
  - S1 registers the three products for every pixel lane, plus in_last.
  - S2 registers the rounded gray byte per lane, plus last.
  - PK is the packer.
- Global advance: en = !out_valid | out_ready.
  - in_ready = en, purely combinational from out_valid and out_ready.
  - All stages load when en is high and hold when en is low.
  - An empty stage propagates a bubble (valid = 0).
- Packer:
  - A 2-bit fill counter (0..3) tracks byte slots.
  - A 32-bit assembly register holds the partial word.
  - When S2 is valid and en is high, PIXELS_PER_IN bytes are written at the slot(s) given by fill, in big-endian order.
  - Word complete (fill wraps to 0), or S2 last set:
    - out_data is loaded with the assembled word; unwritten bytes are 0x00.
    - out_valid is set to 1, and out_last is set to the S2 last bit.
    - fill is reset to 0 and the assembly register is cleared.
  - Otherwise, while en is high, out_valid is cleared to 0.
- in_last on a word that exactly completes an output word yields one word with out_last = 1. No extra empty word is emitted.
- Reset (reset_n = 0 at an edge):
  - All stage valids, fill, out_valid and out_last are cleared to 0, and out_data is cleared to 0x00000000.
  - Partially assembled data and in-flight pixels are discarded.
  - in_ready reads 1 immediately after reset.

## Timing
- Latency: the input word that completes an output word is accepted at edge k. out_valid is high after edge k+3.
- Throughput: one input word per cycle while out_ready stays high.
  - PIXELS_PER_IN = 2: one output word per 2 input words.
  - PIXELS_PER_IN = 1: one output word per 4 input words.
- Backpressure: out_valid = 1 with out_ready = 0 drives in_ready to 0 in the same cycle.
  - The whole pipeline freezes.
  - out_data and out_last hold stable until the word is accepted.
- An input transfer occurs only when in_valid & in_ready. in_valid = 0 inserts bubbles without disturbing fill.
- Simultaneous output accept and a new word completing on the same edge: the new word replaces the old one, with no gap cycle.

## Configuration
- GRAYSCALE_ROUND_EN defined: RND = 128, giving round-half-up.
- GRAYSCALE_ROUND_EN not defined: RND = 0, giving truncation. This saves the rounding adder.
- All other behaviour and latency are identical in both builds.

## Test plan
- Primaries, PIXELS_PER_IN = 2, rounding on:
  - Inputs 0xFFFF0000, then 0xF80007E0 with in_last, out_ready = 1.
  - Expect out_data = 0xFF0036B6, out_last = 1, 3 cycles after the second accept.
  - Without GRAYSCALE_ROUND_EN, expect 0xFF0035B6.
- Partial flush:
  - Single word 0x001FFFFF with in_last.
  - Expect out_data = 0x13FF0000, out_last = 1. Without the macro, expect 0x12FF0000.
- Backpressure:
  - Stream 8 words and hold out_ready = 0 for 5 cycles once out_valid rises.
  - Expect in_ready = 0 throughout, out_data stable, and 4 words delivered in order with no loss or duplication.
- PIXELS_PER_IN = 1:
  - Inputs 0xFFFF, 0x0000, 0x07E0, 0x001F.
  - Expect one word 0xFF00B613 after the fourth accept.
- Reset mid-operation:
  - Accept one word (fill = 2), pulse reset_n low for 1 cycle, then send 0x00000000 and 0xFFFFFFFF with in_last.
  - Expect exactly one word 0x0000FFFF, with no stale bytes from before reset.
- Bubbles:
  - Toggle in_valid every cycle with out_ready = 1.
  - Expect the same output words as the dense stream, with out_valid pulses spaced accordingly.
